// File: rtl/regfile_mp_pkg.sv
// Shared widths, zero-register constant and flattened-bus slicing helper for regfile_mp.
`ifndef REGFILE_MP_SLICE
`define REGFILE_MP_SLICE
`define RF_SLICE(idx, w) (idx)*(w) +: (w)
`endif

package regfile_mp_pkg;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 5;
   localparam int unsigned ZERO_REG   = 0;
endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port with write-through bypass and busy capture.
module regfile_rd_port
   import regfile_mp_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] stored,
   input  logic              busy_nxt,
   input  logic              we0,
   input  logic [ADDR_W-1:0] wa0,
   input  logic [DATA_W-1:0] wd0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] wa1,
   input  logic [DATA_W-1:0] wd1,
   output logic [DATA_W-1:0] rd,
   output logic              rd_busy
);

   logic [DATA_W-1:0] data_c;

   // Bypass priority mirrors storage priority: port 1 over port 0 over array.
   always_comb begin
      data_c = stored;
      if (addr == ADDR_W'(ZERO_REG))
         data_c = '0;
      else if (we1 && (wa1 == addr))
         data_c = wd1;
      else if (we0 && (wa0 == addr))
         data_c = wd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd      <= '0;
         rd_busy <= 1'b0;
      end else begin
         rd      <= data_c;
         rd_busy <= busy_nxt;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD bypassed read ports, busy scoreboard.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we0,
   input  logic [ADDR_W-1:0]        wa0,
   input  logic [DATA_W-1:0]        wd0,
   input  logic                     we1,
   input  logic [ADDR_W-1:0]        wa1,
   input  logic [DATA_W-1:0]        wd1,
   input  logic [NUM_RD*ADDR_W-1:0] ra,
   output logic [NUM_RD*DATA_W-1:0] rd,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   output logic [2**ADDR_W-1:0]     busy_vec
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic              wr0_ok;
   logic              wr1_ok;

   assign wr0_ok   = we0 && (wa0 != ADDR_W'(ZERO_REG));
   assign wr1_ok   = we1 && (wa1 != ADDR_W'(ZERO_REG));
   assign busy_vec = busy_q;

   // Port 1 is written last so it wins a same-address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned n = 0; n < DEPTH; n++)
            mem[n] <= '0;
      end else begin
         if (wr0_ok)
            mem[wa0] <= wd0;
         if (wr1_ok)
            mem[wa1] <= wd1;
      end
   end

   // A reservation outranks a same-edge writeback: it belongs to a newer instruction.
   always_comb begin
      busy_d = busy_q;
      for (int unsigned n = 1; n < DEPTH; n++) begin
         if (rsv_en && (rsv_addr == ADDR_W'(n)))
            busy_d[n] = 1'b1;
         else if ((wr0_ok && (wa0 == ADDR_W'(n))) || (wr1_ok && (wa1 == ADDR_W'(n))))
            busy_d[n] = 1'b0;
      end
      busy_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      assign addr = ra[`RF_SLICE(i, ADDR_W)];

      regfile_rd_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_rd_port (
         .clk      (clk),
         .rst      (rst),
         .addr     (addr),
         .stored   (mem[addr]),
         .busy_nxt (busy_d[addr]),
         .we0      (we0),
         .wa0      (wa0),
         .wd0      (wd0),
         .we1      (we1),
         .wa1      (wa1),
         .wd1      (wd1),
         .rd       (rd[`RF_SLICE(i, DATA_W)]),
         .rd_busy  (rd_busy[i])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (NUM_RD=4, DATA_W=64, ADDR_W=4) with a queued reference model.
module tb_regfile_mp;

   localparam int unsigned DW    = 64;
   localparam int unsigned AW    = 4;
   localparam int unsigned NR    = 4;
   localparam int unsigned DEPTH = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             we0, we1, rsv_en;
   logic [AW-1:0]    wa0, wa1, rsv_addr;
   logic [DW-1:0]    wd0, wd1;
   logic [NR*AW-1:0] ra;
   logic [NR*DW-1:0] rd;
   logic [NR-1:0]    rd_busy;
   logic [DEPTH-1:0] busy_vec;

   logic [DW-1:0]    mmem [DEPTH];
   logic [DEPTH-1:0] mbusy;

   logic [NR*DW-1:0] q_rd   [$];
   logic [NR-1:0]    q_busy [$];
   logic [DEPTH-1:0] q_vec  [$];

   int total = 0;
   int bad   = 0;

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
      .clk      (clk),
      .rst      (rst),
      .we0      (we0),
      .wa0      (wa0),
      .wd0      (wd0),
      .we1      (we1),
      .wa1      (wa1),
      .wd1      (wd1),
      .ra       (ra),
      .rd       (rd),
      .rd_busy  (rd_busy),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .busy_vec (busy_vec)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      we0 = 1'b0; wa0 = '0; wd0 = '0;
      we1 = 1'b0; wa1 = '0; wd1 = '0;
      rsv_en = 1'b0; rsv_addr = '0;
      ra = '0;
   endtask

   task automatic set_ra(input int p, input logic [AW-1:0] a);
      ra[p*AW +: AW] = a;
   endtask

   task automatic model_reset();
      for (int n = 0; n < int'(DEPTH); n++) mmem[n] = '0;
      mbusy = '0;
   endtask

   // Predict the edge from the model, push, clock, then pop and compare.
   task automatic step(input string tag);
      logic [NR*DW-1:0] erd;
      logic [NR-1:0]    eb;
      logic [DEPTH-1:0] nb;
      logic [AW-1:0]    a;
      logic [NR*DW-1:0] xrd;
      logic [NR-1:0]    xb;
      logic [DEPTH-1:0] xv;
      nb = mbusy;
      for (int n = 1; n < int'(DEPTH); n++) begin
         if (rsv_en && int'(rsv_addr) == n) nb[n] = 1'b1;
         else if ((we0 && int'(wa0) == n) || (we1 && int'(wa1) == n)) nb[n] = 1'b0;
      end
      for (int p = 0; p < int'(NR); p++) begin
         a = ra[p*AW +: AW];
         if (a == 0)                  erd[p*DW +: DW] = '0;
         else if (we1 && wa1 == a)    erd[p*DW +: DW] = wd1;
         else if (we0 && wa0 == a)    erd[p*DW +: DW] = wd0;
         else                         erd[p*DW +: DW] = mmem[a];
         eb[p] = nb[a];
      end
      if (we0 && wa0 != 0) mmem[wa0] = wd0;
      if (we1 && wa1 != 0) mmem[wa1] = wd1;
      mbusy = nb;
      q_rd.push_back(erd);
      q_busy.push_back(eb);
      q_vec.push_back(nb);
      @(posedge clk);
      #1;
      xrd = q_rd.pop_front();
      xb  = q_busy.pop_front();
      xv  = q_vec.pop_front();
      for (int p = 0; p < int'(NR); p++)
         chk($sformatf("%s/rd%0d", tag, p), rd[p*DW +: DW], xrd[p*DW +: DW]);
      chk({tag, "/rd_busy"},  DW'(rd_busy),  DW'(xb));
      chk({tag, "/busy_vec"}, DW'(busy_vec), DW'(xv));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      model_reset();
      #3 rst = 1'b1;
      #1;
      chk("rst/rd",       DW'(rd),       '0);
      chk("rst/rd_busy",  DW'(rd_busy),  '0);
      chk("rst/busy_vec", DW'(busy_vec), '0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // reads after reset return zero
      for (int p = 0; p < int'(NR); p++) set_ra(p, AW'(p + 3));
      step("post_rst");

      idle(); we0 = 1'b1; wa0 = 4'd3; wd0 = 64'hDEADBEEF;
      step("wr3");
      idle(); set_ra(0, 4'd3);
      step("rd3");
      chk("rd3_const", rd[DW-1:0], 64'hDEADBEEF);

      idle(); we0 = 1'b1; wa0 = 4'd0; wd0 = 64'hFFFFFFFF;
      we1 = 1'b1; wa1 = 4'd0; wd1 = 64'hFFFFFFFF; set_ra(1, 4'd0);
      step("wr0");
      idle(); set_ra(0, 4'd0);
      step("rd0");
      chk("rd0_const", rd[DW-1:0], '0);

      idle(); we0 = 1'b1; wa0 = 4'd7; wd0 = 64'h1111;
      we1 = 1'b1; wa1 = 4'd7; wd1 = 64'h2222; set_ra(0, 4'd7);
      step("coll");
      chk("coll_byp_const", rd[DW-1:0], 64'h2222);
      idle(); set_ra(2, 4'd7);
      step("coll_rd");
      chk("coll_rd_const", rd[2*DW +: DW], 64'h2222);

      idle(); we0 = 1'b1; wa0 = 4'd9; wd0 = 64'h0BAD;
      step("pre9");
      idle(); we0 = 1'b1; wa0 = 4'd9; wd0 = 64'hA5A5A5A5;
      set_ra(0, 4'd9); set_ra(1, 4'd9);
      step("byp9");
      chk("byp9_p0_const", rd[0 +: DW],  64'hA5A5A5A5);
      chk("byp9_p1_const", rd[DW +: DW], 64'hA5A5A5A5);

      idle(); rsv_en = 1'b1; rsv_addr = 4'd12; set_ra(0, 4'd12);
      step("rsv12");
      chk("rsv12_const", DW'(busy_vec[12]), 64'd1);
      idle(); we1 = 1'b1; wa1 = 4'd12; wd1 = 64'h1234; set_ra(0, 4'd12);
      step("wr12");
      chk("wr12_const", DW'(busy_vec[12]), 64'd0);
      idle(); rsv_en = 1'b1; rsv_addr = 4'd12;
      we0 = 1'b1; wa0 = 4'd12; wd0 = 64'h5678; set_ra(3, 4'd12);
      step("rsvwr12");
      chk("rsvwr12_busy_const", DW'(busy_vec[12]), 64'd1);
      chk("rsvwr12_data_const", rd[3*DW +: DW], 64'h5678);
      idle(); rsv_en = 1'b1; rsv_addr = 4'd0;
      step("rsv0");
      chk("rsv0_const", DW'(busy_vec[0]), 64'd0);

      // reset mid-cycle drops the in-flight write and reserve
      idle(); we0 = 1'b1; wa0 = 4'd5; wd0 = 64'hCAFE; rsv_en = 1'b1; rsv_addr = 4'd5;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst/rd",       DW'(rd),       '0);
      chk("mid_rst/rd_busy",  DW'(rd_busy),  '0);
      chk("mid_rst/busy_vec", DW'(busy_vec), '0);
      model_reset();
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      idle(); set_ra(0, 4'd5); set_ra(1, 4'd12); set_ra(2, 4'd3);
      step("after_mid_rst");

      for (int c = 0; c < 10000; c++) begin
         we0 = 1'($urandom_range(0, 1)); wa0 = AW'($urandom_range(0, DEPTH - 1));
         wd0 = {32'($urandom), 32'($urandom)};
         we1 = 1'($urandom_range(0, 1)); wa1 = AW'($urandom_range(0, DEPTH - 1));
         wd1 = {32'($urandom), 32'($urandom)};
         rsv_en = 1'($urandom_range(0, 2) == 0); rsv_addr = AW'($urandom_range(0, DEPTH - 1));
         for (int p = 0; p < int'(NR); p++) set_ra(p, AW'($urandom_range(0, DEPTH - 1)));
         step("rand");
         for (int p = 0; p < int'(NR); p++)
            chk("rand/busy_track", DW'(rd_busy[p]), DW'(busy_vec[ra[p*AW +: AW]]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; the next generation of the processor's register bank.
- Configurable data width, depth and read-port count; two write ports with defined priority.
- Reads are registered and write-through bypassed; register 0 is hardwired to zero.
- Per-register busy scoreboard lets the decode/hazard unit stall on pending writebacks.
- Sits between decode (read/reserve) and writeback (write).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
we0  in  1  write enable, write port 0
wa0  in  ADDR_W  write address, port 0
wd0  in  DATA_W  write data, port 0
we1  in  1  write enable, write port 1 (higher priority)
wa1  in  ADDR_W  write address, port 1
wd1  in  DATA_W  write data, port 1
ra  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
rd  out  NUM_RD*DATA_W  registered read data; port i occupies bits [i*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  registered busy flag of the addressed register, per read port
rsv_en  in  1  reserve request: mark register rsv_addr busy
rsv_addr  in  ADDR_W  register to reserve
busy_vec  out  2**ADDR_W  live scoreboard, bit n = register n busy

Behaviour:
- Reset (rst=1, asynchronous): all registers cleared to 0; busy_vec = 0; rd = 0; rd_busy = 0. Reset asserted mid-operation discards any in-flight write or reserve on that edge.
- Write: on a rising edge with weK=1 and waK!=0, register[waK] <= wdK. Writes to address 0 are ignored.
- Both write ports to the same nonzero address on one edge: port 1 data is stored; port 0 is dropped.
- Read latency is 1 cycle. On each rising edge, read port i captures:
  - 0 if its address is 0;
  - else wd1 if we1 && wa1==addr;
  - else wd0 if we0 && wa0==addr;
  - else the stored register.
- rd therefore shows the value as written on that edge (write-through bypass). The bypass follows the same priority as the storage.
- Scoreboard, per nonzero register n, on each rising edge:
  - set if rsv_en && rsv_addr==n;
  - else cleared if any write port writes n;
  - else held.
- Reserve and write to the same register on one edge: the register is written and stays busy, because the reservation belongs to a newer instruction.
- Reserving register 0 has no effect; busy_vec[0] is always 0.
- rd_busy[i] is registered alongside rd[i] and reflects the post-edge scoreboard value for ra_i. It equals busy_vec[ra_i] as it reads after the edge.
- busy_vec is a direct register output with no combinational path from inputs.
- No X propagation: all ports are defined from reset onward.

Decomposition:
- Shared package/include holds the default widths (DATA_W=32, ADDR_W=5), the zero-register address constant ZERO_REG=0, and the port-slicing helper macros for the flattened ra/rd buses.
- One natural sub-module, regfile_rd_port: a single read port's bypass mux and output register. Instantiate it NUM_RD times in a generate loop.
- Storage, write priority and scoreboard stay in the top module.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle -> rd=0, rd_busy=0, busy_vec=0 immediately. After release, reading any address returns 0.
- Basic write/read:
  - we0=1, wa0=3, wd0=32'hDEADBEEF for one edge, then ra port0=3 -> rd port0 = 32'hDEADBEEF one edge later.
  - Write to address 0 with 32'hFFFFFFFF, then read address 0 -> rd = 0.
- Dual-write collision: we0=1, wa0=7, wd0=32'h1111 and we1=1, wa1=7, wd1=32'h2222 on the same edge -> bypassed read of 7 that edge returns 32'h2222, and a later read also returns 32'h2222.
- Bypass: write 32'hA5A5A5A5 to register 9 while port0 and port1 both read 9 on the same edge -> both rd ports show 32'hA5A5A5A5 after that edge, not the old value.
- Scoreboard:
  - rsv_en=1, rsv_addr=12 -> busy_vec[12]=1 next edge.
  - Write 12 -> busy_vec[12]=0.
  - Reserve 12 and write 12 on the same edge -> busy_vec[12] stays 1 and the data is updated.
  - rsv_addr=0 -> busy_vec[0] stays 0.
- Parameter sweep: NUM_RD=4, DATA_W=64, ADDR_W=4 -> random writes and reads against a reference model for 10k cycles with zero mismatches; all four rd_busy bits track busy_vec.
